// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution output-buffer blocks.
//   - Frame geometry shared by rom_write (producer) and rom_read (consumer).
//   - pixel_t: one output pixel.
//   - state_t: sequencing states of the rom_read engine.
package conv_pkg;

  localparam int OUT_WIDTH  = 30;
  localparam int OUT_HEIGHT = 30;
  localparam int FRAME_PIX  = OUT_WIDTH * OUT_HEIGHT;
  localparam int DATA_W     = 32;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_read_fifo.sv
// rom_read_fifo: synchronous single-clock FIFO used as the output buffer of
// rom_read.
// Ports:
//   clk, rst            clock, synchronous active-high flush
//   push, push_data     write side (push ignored when full)
//   pop, pop_data       read side; pop_data shows the head entry, 0 when empty
//   count, empty, full  occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_read_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is masked when empty so the stream data reads as 0 after a flush.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // The issue credit upstream guarantees a push never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/rom_read.sv
// rom_read: read-back engine for the convolution output buffer.
// On start it reads RAM addresses 0..OUT_WIDTH*OUT_HEIGHT-1 through a
// synchronous read port and replays the pixels as a stream with end-of-row
// (pix_eol) and end-of-frame (pix_last) markers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle frame request (honoured only in IDLE)
//   rd_en, rd_addr, rd_data  RAM read port; rd_data valid 1 cycle after rd_en
//   pix_valid, pix_ready     stream handshake
//   pix_data, pix_eol, pix_last  stream payload
//   busy                     high while the frame is being read / drained
//   done                     one-cycle pulse after the last transfer
//   checksum                 frame sum of transferred pixels (0 unless built
//                            with ROM_READ_CHECKSUM_EN)
// Handshake: a pixel moves on every cycle where pix_valid && pix_ready. Once
// pix_valid is high it stays high, with pix_data/pix_eol/pix_last unchanged,
// until that transfer happens.
// Optional feature macro: ROM_READ_CHECKSUM_EN.
// FSM state is visible hierarchically as state_q.
module rom_read #(
  parameter int OUT_WIDTH  = conv_pkg::OUT_WIDTH,
  parameter int OUT_HEIGHT = conv_pkg::OUT_HEIGHT,
  parameter int DATA_W     = conv_pkg::DATA_W,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  import conv_pkg::*;

  localparam int N  = OUT_WIDTH * OUT_HEIGHT;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + 2;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] col_q;
  logic [ADDR_W-1:0] row_q;
  logic              stg_vld_q;
  logic              stg_eol_q;
  logic              stg_last_q;
  logic [1:0]        inflight_q;

  logic              accept;
  logic              issue;
  logic              is_eol;
  logic              is_last;
  logic              pop;
  logic [31:0]       credit_used;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [EW-1:0]     fifo_out;

  assign accept  = (state_q == IDLE) && start;
  assign is_eol  = (col_q == ADDR_W'(OUT_WIDTH - 1));
  assign is_last = (idx_q == ADDR_W'(N - 1));

  // Credit counts buffered entries plus reads still in the pipe; a pop in the
  // same cycle is deliberately not counted so the buffer can never overflow.
  assign credit_used = 32'(fifo_count) + 32'(inflight_q);
  assign issue       = (state_q == RUN) && (credit_used < 32'(FIFO_DEPTH));

  assign rd_en   = issue;
  assign rd_addr = issue ? idx_q : '0;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign {pix_data, pix_eol, pix_last} = fifo_out;

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (issue && is_last) state_d = DRAIN;
      // Leave as the final entry is popped so done lands one cycle after it.
      DRAIN: if ((inflight_q == 2'd0) &&
                 (fifo_empty || ((fifo_count == CW'(1)) && pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_eol_q  <= 1'b0;
      stg_last_q <= 1'b0;
      inflight_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
        col_q <= '0;
        row_q <= '0;
      end else if (issue) begin
        idx_q <= is_last ? '0 : idx_q + ADDR_W'(1);
        if (is_eol) begin
          col_q <= '0;
          row_q <= is_last ? '0 : row_q + ADDR_W'(1);
        end else begin
          col_q <= col_q + ADDR_W'(1);
        end
      end
      // Delay stage: markers travel alongside the read so they line up with
      // rd_data, which the RAM returns in the following cycle.
      stg_vld_q  <= issue;
      stg_eol_q  <= issue && is_eol;
      stg_last_q <= issue && is_last;
      inflight_q <= inflight_q + 2'(issue) - 2'(stg_vld_q);
    end
  end

  rom_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stg_vld_q),
    .push_data ({rd_data, stg_eol_q, stg_last_q}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef ROM_READ_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + 32'(pix_data);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight_q <= 2'd2);
  a_push_room:    assert property (@(posedge clk) disable iff (rst) stg_vld_q |-> !fifo_full);

endmodule

// File: tb/tb_rom_read.sv
// tb_rom_read: self-checking bench for rom_read.
// Holds a RAM model, a pixel-level reference (expected queue of
// {data, eol, last} built from frame index arithmetic) and an address model.
// Optional feature macro: ROM_READ_CHECKSUM_EN (selects the checksum
// expectation).
module tb_rom_read;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int N  = W * H;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FD = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_eol;
  logic          pix_last;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  rom_read #(
    .OUT_WIDTH  (W),
    .OUT_HEIGHT (H),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_eol   (pix_eol),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  // Synchronous-read RAM model
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW+1:0] exp_q[$];
  logic [31:0]   exp_sum;
  int            exp_addr;
  int            n_issued, n_xfer;
  int            first_rd, first_vld, last_xfer, done_cyc, start_cyc;
  bit            done_seen;
  int            rdy_mode;
  bit            prev_stall, prev_rst;
  logic [DW+1:0] prev_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_en) begin
      check("rd_addr", 64'(rd_addr), 64'(exp_addr));
      check("addr_range", 64'(int'(rd_addr) < N), 64'(1));
      exp_addr++;
      n_issued++;
      if (first_rd < 0) first_rd = cyc;
      check("credit", 64'((n_issued - n_xfer) <= FD), 64'(1));
    end
    if (pix_valid && first_vld < 0) first_vld = cyc;
    if (prev_stall && !prev_rst) begin
      check("hold_valid", 64'(pix_valid), 64'(1));
      check("hold_data", 64'({pix_data, pix_eol, pix_last}), 64'(prev_word));
    end
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) check("unexpected_xfer", 64'(1), 64'(0));
      else check("pix", 64'({pix_data, pix_eol, pix_last}), 64'(exp_q.pop_front()));
      n_xfer++;
      last_xfer = cyc;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    prev_stall = pix_valid && !pix_ready;
    prev_word  = {pix_data, pix_eol, pix_last};
    prev_rst   = rst;
  end

  // ---------------- drivers ----------------
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic fill_frame(input int base);
    logic [DW-1:0] d;
    logic          e, l;
    exp_q.delete();
    exp_sum  = '0;
    exp_addr = 0;
    for (int i = 0; i < N; i++) begin
      d = DW'(base + i);
      e = ((i % W) == W - 1);
      l = (i == N - 1);
      ram[i] = d;
      exp_q.push_back({d, e, l});
      exp_sum = exp_sum + d;
    end
  endtask

  task automatic clr_track();
    n_issued  = 0;
    n_xfer    = 0;
    first_rd  = -1;
    first_vld = -1;
    last_xfer = -1;
    done_cyc  = -1;
    done_seen = 1'b0;
  endtask

  task automatic pulse_start(input bit accepted);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (accepted) start_cyc = cyc;
  endtask

  task automatic wait_done(input int limit);
    int i = 0;
    while (!done_seen && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    check("done_timeout", 64'(done_seen), 64'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},     64'(rd_en),     64'(0));
    check({tag, "_rd_addr"},   64'(rd_addr),   64'(0));
    check({tag, "_pix_valid"}, 64'(pix_valid), 64'(0));
    check({tag, "_pix_data"},  64'(pix_data),  64'(0));
    check({tag, "_pix_eol"},   64'(pix_eol),   64'(0));
    check({tag, "_pix_last"},  64'(pix_last),  64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_done"},      64'(done),      64'(0));
    check({tag, "_checksum"},  64'(checksum),  64'(0));
  endtask

  task automatic check_frame(input bit timing);
    wait_done(4000);
    check("xfer_count", 64'(n_xfer), 64'(N));
    check("exp_left", 64'(exp_q.size()), 64'(0));
    check("done_after_last", 64'(done_cyc - last_xfer), 64'(1));
    check("busy_after_done", 64'(busy), 64'(0));
    if (timing) begin
      check("lat_first_rd", 64'(first_rd - start_cyc), 64'(0));
      check("lat_first_vld", 64'(first_vld - start_cyc), 64'(2));
      check("lat_last_xfer", 64'(last_xfer - start_cyc), 64'(N + 1));
      check("lat_done", 64'(done_cyc - start_cyc), 64'(N + 2));
    end
`ifdef ROM_READ_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(exp_sum));
    @(posedge clk); #1;
    check("checksum_stable", 64'(checksum), 64'(exp_sum));
`else
    check("checksum_off", 64'(checksum), 64'(0));
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int i;
    rst      = 1'b1;
    start    = 1'b0;
    rdy_mode = 1;
    exp_addr = 0;
    clr_track();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset");

    // Full frame, sink always ready
    fill_frame(32'h100);
    clr_track();
    rdy_mode = 1;
    pulse_start(1'b1);
    check_frame(1'b1);

    // Same frame, random back-pressure
    fill_frame(32'h100);
    clr_track();
    rdy_mode = 2;
    pulse_start(1'b1);
    check_frame(1'b0);

    // Sink blocked for 20 cycles: only the buffer's worth of reads may issue
    fill_frame(32'h5000);
    clr_track();
    rdy_mode = 0;
    pulse_start(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("blocked_reads", 64'(n_issued), 64'(FD));
    check("blocked_rd_en", 64'(rd_en), 64'(0));
    check("blocked_busy", 64'(busy), 64'(1));
    rdy_mode = 1;
    check_frame(1'b0);

    // start during RUN and during DONE are ignored; start right after done works
    fill_frame(32'h200);
    clr_track();
    rdy_mode = 1;
    pulse_start(1'b1);
    repeat (100) @(posedge clk);
    #1;
    pulse_start(1'b0);
    check("run_busy", 64'(busy), 64'(1));
    i = 0;
    while (!done && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    check("t4_done", 64'(done), 64'(1));
    start = 1'b1;
    check("t4_xfer_count", 64'(n_xfer), 64'(N));
    @(posedge clk); #1;
    check("t4_idle_busy", 64'(busy), 64'(0));
    check("t4_idle_rd_en", 64'(rd_en), 64'(0));
    check("t4_exp_left", 64'(exp_q.size()), 64'(0));
    fill_frame(32'h300);
    clr_track();
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check_frame(1'b1);

    // Reset mid-frame with a coincident start
    fill_frame(32'h400);
    clr_track();
    rdy_mode = 1;
    pulse_start(1'b1);
    i = 0;
    while (n_xfer < N / 2 && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    check("reach_half", 64'(n_xfer >= N / 2), 64'(1));
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check_outputs_zero("midrst");
    exp_q.delete();
    clr_track();
    repeat (10) @(posedge clk);
    #1;
    check("rst_start_ignored", 64'(n_issued), 64'(0));
    check("rst_idle_busy", 64'(busy), 64'(0));

    // Restart from address 0 with RAM[i] = i
    fill_frame(0);
    clr_track();
    pulse_start(1'b1);
    check_frame(1'b1);
`ifdef ROM_READ_CHECKSUM_EN
    check("checksum_ref", 64'(checksum), 64'(32'd404550));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_read.md
Name: rom_read

Overview:
- Read-back engine for the convolution output buffer; the consumer side of the result RAM that rom_write fills.
- On a start pulse, typically driven from write_fin, it walks addresses 0..OUT_WIDTH*OUT_HEIGHT-1 through the RAM's synchronous read port.
- It re-emits the pixels as a valid/ready stream with end-of-row and end-of-frame markers.
- Consumers are a UART/AXI-stream dump or a checker.

Parameters:
- OUT_WIDTH, 30, pixels per output row
- OUT_HEIGHT, 30, output rows
- DATA_W, 32, pixel width
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= OUT_WIDTH*OUT_HEIGHT
- FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to read one full frame
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en
- pix_valid  out  1  stream data valid
- pix_ready  in  1  stream sink ready
- pix_data  out  DATA_W  pixel
- pix_eol  out  1  qualifies the last pixel of a row (col == OUT_WIDTH-1)
- pix_last  out  1  qualifies the last pixel of the frame
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel has been transferred
- checksum  out  32  frame checksum (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-high; rst dominates all other inputs and beats start in the same cycle.
  - State -> IDLE; FIFO flushed; address and row/col counters cleared.
  - rd_en, rd_addr, pix_valid, pix_data, pix_eol, pix_last, busy, done, checksum all 0.
  - Mid-frame reset abandons the frame; the next start restarts at address 0.
- FSM states:
  - IDLE: start=1 -> RUN; clear rd_addr counter. start is ignored in every other state.
  - RUN: issue one read per cycle while credit allows. When address N-1 (N=OUT_WIDTH*OUT_HEIGHT) is issued -> DRAIN.
  - DRAIN: no reads. When FIFO is empty and inflight==0 -> DONE.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- Read issue:
  - rd_en=1 with rd_addr=current index.
  - inflight = reads issued whose data has not yet been pushed (0..2).
  - Credit: issue only if fifo_count + inflight < FIFO_DEPTH. A pop in the same cycle is not credited.
  - FIFO overflow is impossible by construction; an assertion must check it.
- Data path:
  - rd_data is captured into a delay stage 1 cycle after rd_en, then pushed into the FIFO on the next edge.
  - The FIFO carries {data, eol, last}, where eol/last are computed from row/col counters at issue time.
- Latency:
  - start sampled at edge k; first rd_en in cycle k+1; first pix_valid in cycle k+3.
  - With pix_ready held at 1: one pixel per cycle, so a 900-pixel frame ends with its last transfer in cycle k+902 and done in cycle k+903.
- Stream rules:
  - pix_valid = FIFO non-empty.
  - Transfer when pix_valid & pix_ready.
  - While pix_valid & !pix_ready, pix_data/eol/last are held stable.
  - pix_valid is never withdrawn without a transfer.
  - pix_ready may toggle arbitrarily; a pix_ready stuck at 0 leaves the block in RUN/DRAIN indefinitely.
- Counters:
  - col wraps OUT_WIDTH-1 -> 0 and increments row.
  - rd_addr is never driven >= N.
  - Stream arithmetic is unsigned and sized to ADDR_W.
- busy=1 in RUN and DRAIN.

Optional Feature:
- Macro: ROM_READ_CHECKSUM_EN.
- With macro defined:
  - checksum is cleared on accepted start.
  - It accumulates (checksum + pix_data) mod 2^32 on every transfer.
  - It is final and stable from the done cycle until the next start or reset.
- Without macro: checksum tied to 0 and no adder logic is generated.

Decomposition:
- Shared package conv_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Frame constants OUT_WIDTH, OUT_HEIGHT, FRAME_PIX, shared with rom_write.
  - pixel_t typedef (DATA_W wide).
- One sub-module: rom_read_fifo, a synchronous FIFO of depth FIFO_DEPTH.
  - Ports: push/pop/data, plus count, empty, full.
  - It is flushed by rst.

Test Plan:
- Preload RAM[i]=i+0x100 for i=0..899; start with pix_ready=1:
  - 900 transfers, data 0x100..0x483 in order.
  - pix_eol at indices 29, 59, ..., 899.
  - pix_last only at index 899.
  - First pix_valid 3 cycles after start; done 1 cycle after the last transfer.
- Random pix_ready (50%) over the same frame:
  - Identical data sequence.
  - Data held stable during stalls.
  - FIFO never overflows; inflight never exceeds 2.
- pix_ready=0 for 20 cycles after start:
  - Exactly 4 reads issued (FIFO_DEPTH), then rd_en stays 0.
  - Releasing ready resumes the sequence without loss or duplication.
- start pulsed during RUN and again during DONE:
  - Both ignored.
  - A start one cycle after done returns to IDLE correctly and begins a second full frame from address 0.
- rst asserted at pixel 450, then start:
  - All outputs 0 the cycle after rst.
  - Restart delivers addresses from 0.
  - start coincident with rst is ignored.
- ROM_READ_CHECKSUM_EN with RAM[i]=i:
  - checksum = 404550 (0x62C46) at done.
  - With the macro undefined, checksum stays 0.
